// File: rtl/da2_sample_sched.sv
// Purpose: paces two filter channels onto a dual 12-bit DAC, one update strobe per sample period.
// Latency: a held sample reaches value0/value1 at the next tick's LOAD; update follows LOAD by one cycle.
// Backpressure: each channel has a one-deep holding register; sx_ready drops while a code is pending.
module da2_sample_sched #(
  parameter int SAMPLE_DIV  = 2500,
  parameter int XFER_CYCLES = 450
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] s0_data,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [15:0] s1_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [11:0] value0,
  output logic [11:0] value1,
  output logic        update,
  output logic [1:0]  underrun,
  output logic        overrun,
  input  logic        clear_flags
);

  localparam int TW = $clog2(SAMPLE_DIV + 1);
  localparam int BW = $clog2(XFER_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BUSY_LOAD = BW'(XFER_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] busy_cnt;
  logic          tick;
  logic          in_load;
  logic          pend0, pend1;
  logic [11:0]   hold0, hold1;

  // The three sub-LSB bits carry no information once rounded on bit 3.
  logic unused_lsbs;
  assign unused_lsbs = ^{s0_data[2:0], s1_data[2:0]};

  // Q1.15 -> 12-bit offset binary: round half up on bit 3, clamp the single
  // positive overflow case (0x7FF + 1), then flip the sign bit.
  function automatic logic [11:0] to_code(input logic [12:0] d);
    logic [12:0] r;
    logic [11:0] s;
    r = {d[12], d[12:1]} + {12'd0, d[0]};
    if (!r[12] && r[11]) s = 12'h7FF;
    else                 s = r[11:0];
    return {~s[11], s[10:0]};
  endfunction

  assign tick     = en & (tick_cnt == TICK_LAST);
  assign in_load  = (state == ST_LOAD);
  assign s0_ready = ~pend0;
  assign s1_ready = ~pend1;

  // Sample-period counter; parked at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tick_cnt <= '0;
    else if (!en)               tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + TW'(1);
  end

  // Channel 0 holding register; a pending code can't be accepted and consumed in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend0 <= 1'b0;
      hold0 <= 12'h800;
    end else if (s0_valid && !pend0) begin
      pend0 <= 1'b1;
      hold0 <= to_code(s0_data[15:3]);
    end else if (in_load) begin
      pend0 <= 1'b0;
    end
  end

  // Channel 1 holding register, same scheme as channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend1 <= 1'b0;
      hold1 <= 12'h800;
    end else if (s1_valid && !pend1) begin
      pend1 <= 1'b1;
      hold1 <= to_code(s1_data[15:3]);
    end else if (in_load) begin
      pend1 <= 1'b0;
    end
  end

  // IDLE -> LOAD on tick, LOAD -> BUSY for XFER_CYCLES cycles, back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (tick) state <= ST_LOAD;
        ST_LOAD: begin
          state    <= ST_BUSY;
          busy_cnt <= BUSY_LOAD;
        end
        ST_BUSY: begin
          if (busy_cnt == '0) state <= ST_IDLE;
          else                busy_cnt <= busy_cnt - BW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output codes latch in LOAD so they are settled when update fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value0 <= 12'h800;
      value1 <= 12'h800;
      update <= 1'b0;
    end else begin
      update <= in_load;
      if (in_load && pend0) value0 <= hold0;
      if (in_load && pend1) value1 <= hold1;
    end
  end

  // Sticky error flags; a set in the same cycle as clear_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 2'b00;
      overrun  <= 1'b0;
    end else begin
      if (in_load && !pend0)  underrun[0] <= 1'b1;
      else if (clear_flags)   underrun[0] <= 1'b0;
      if (in_load && !pend1)  underrun[1] <= 1'b1;
      else if (clear_flags)   underrun[1] <= 1'b0;
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      else if (clear_flags)         overrun <= 1'b0;
    end
  end

endmodule

// File: doc/da2_sample_sched.md
DA2_SAMPLE_SCHED -- requirements
Module: da2_sample_sched

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 2500, meaning clk cycles per DAC sample period (40 kHz at 100 MHz).
REQ-002 SHALL have parameter XFER_CYCLES, default 450, meaning clk cycles the DAC serializer is busy after an update pulse.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: scheduler enable; when low, the tick counter holds at 0 and no new updates start.
REQ-006 SHALL have ports s0_data / s1_data, input, 16 bits each: signed Q1.15 sample from filter channel 0 / 1.
REQ-007 SHALL have ports s0_valid / s1_valid, input, 1 bit each: sample offered on the channel.
REQ-008 SHALL have ports s0_ready / s1_ready, output, 1 bit each: channel holding register free.
REQ-009 SHALL have ports value0 / value1, output, 12 bits each: offset-binary codes to the dual DAC driver.
REQ-010 SHALL have port update, output, 1 bit: one-cycle strobe that launches a DAC transfer.
REQ-011 SHALL have ports underrun, output, 2 bits, and overrun, output, 1 bit: sticky error flags.
REQ-012 SHALL have port clear_flags, input, 1 bit: synchronous clear of all sticky flags.

Function
REQ-013 The tick counter SHALL count 0..SAMPLE_DIV-1 while en=1, wrap to 0, and assert an internal tick in the cycle it holds SAMPLE_DIV-1.
REQ-014 Each channel SHALL have a one-deep holding register plus a pend flag; sx_ready = ~pend.
REQ-015 A transfer SHALL occur when sx_valid & sx_ready; the converted code is stored and pend is set on the next edge.
REQ-016 Conversion SHALL be: r = d[15:4] + d[3] (round half up, signed 12-bit), saturated to +2047 on overflow, then MSB inverted to offset binary (0x000 = -FS, 0x800 = 0, 0xFFF = +FS).
REQ-017 FSM states SHALL be IDLE, LOAD and BUSY; reset state is IDLE.
REQ-018 IDLE -> LOAD SHALL occur on tick with en=1.
REQ-019 In LOAD, for each channel with pend=1, valuex SHALL take the held code and pend SHALL clear; with pend=0, valuex SHALL hold its previous code and underrun[x] SHALL set.
REQ-020 update SHALL be high exactly during the cycle after LOAD, coincident with the first BUSY cycle, with value0/value1 already stable.
REQ-021 BUSY SHALL last exactly XFER_CYCLES cycles via a down-counter, then return to IDLE.
REQ-022 A tick arriving while in LOAD or BUSY SHALL be dropped, set overrun, and not queue.
REQ-023 A sample offered in the same cycle LOAD clears pend SHALL NOT be accepted (ready sampled pre-edge); it is accepted on the following cycle.
REQ-024 clear_flags coincident with a flag-setting event SHALL leave the flag set (set wins).
REQ-025 Deasserting en mid-BUSY SHALL let the current transfer complete; no further LOAD until en=1 and the next tick.
REQ-026 The design SHALL require SAMPLE_DIV >= XFER_CYCLES + 3; this is a parameter constraint, not checked in hardware.

Reset
REQ-027 On rst: state=IDLE, tick and busy counters=0, pend=0 (s0_ready=s1_ready=1), value0=value1=12'h800 (mid-scale), update=0, underrun=0, overrun=0.
REQ-028 rst asserted mid-BUSY SHALL abort immediately; no update pulse SHALL follow until a fresh tick after release.

Verification (SAMPLE_DIV=20, XFER_CYCLES=8)
REQ-029 Reset check: after rst -> value0=value1=0x800, update=0, both ready=1, flags=0.
REQ-030 Steady state: s0=0x4000, s1=0xC000 offered every period -> value0=0xC00, value1=0x400, exactly one update per 20 clocks, flags stay 0.
REQ-031 Rounding/saturation: s0=0x7FF8 -> 0xFFF; s0=0x8000 -> 0x000; s0=0x0008 -> 0x801.
REQ-032 Underrun: only s0 fed -> value1 holds its previous code, underrun=2'b10, update still issued each period; clear_flags -> 0.
REQ-033 Overrun: force SAMPLE_DIV=8 with XFER_CYCLES=8 -> overrun=1 and no back-to-back update.
REQ-034 Async reset asserted 3 cycles into BUSY -> immediate reset values, no stray update after release.
